// File: rtl/lut_access_ctrl_if.sv
// Bus bundle for lut_access_ctrl: two read requesters, the config write port and the busy flag.
// master = the side issuing requests; slave = the table controller.
interface lut_access_ctrl_if #(
    parameter int LOG2_WIDTH = 3,
    parameter int WIDTH      = 2**LOG2_WIDTH
);
    logic                  busy;

    logic                  req0_valid;
    logic [LOG2_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [WIDTH-1:0]      rsp0_data;

    logic                  req1_valid;
    logic [LOG2_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [WIDTH-1:0]      rsp1_data;

    logic                  cfg_we;
    logic [LOG2_WIDTH-1:0] cfg_addr;
    logic [WIDTH-1:0]      cfg_data;
    logic                  cfg_ready;

    modport master (
        input  busy,
        output req0_valid, req0_addr, input req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr, input req1_ready, rsp1_valid, rsp1_data,
        output cfg_we, cfg_addr, cfg_data, input cfg_ready
    );

    modport slave (
        output busy,
        input  req0_valid, req0_addr, output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr, output req1_ready, rsp1_valid, rsp1_data,
        input  cfg_we, cfg_addr, cfg_data, output cfg_ready
    );
endinterface

// File: rtl/lut_access_ctrl.sv
// Lookup-table owner: fills entry j with j+1 after reset, then serves two round-robin
// readers (1-cycle latency) and a config write port that always wins the table.
module lut_access_ctrl #(
    parameter  int LOG2_WIDTH = 3,
    localparam int WIDTH      = 2**LOG2_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    lut_access_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [LOG2_WIDTH-1:0] r_init_cnt;
    logic                  r_busy;
    logic                  r_rr_prio;
    logic [WIDTH-1:0]      r_lut [WIDTH];

    logic                  r_rsp_valid [2];
    logic [WIDTH-1:0]      r_rsp_data  [2];

    logic                  w_run;
    logic                  w_cfg_go;
    logic                  w_we;
    logic [LOG2_WIDTH-1:0] w_waddr;
    logic [WIDTH-1:0]      w_wdata;
    logic                  w_req_valid [2];
    logic [LOG2_WIDTH-1:0] w_req_addr  [2];
    logic                  w_grant     [2];

    assign w_req_valid[0] = bus.req0_valid;
    assign w_req_valid[1] = bus.req1_valid;
    assign w_req_addr[0]  = bus.req0_addr;
    assign w_req_addr[1]  = bus.req1_addr;

    assign w_run    = (r_state == ST_RUN);
    assign w_cfg_go = w_run & bus.cfg_we;

    // r_rr_prio names the requester that wins the next tie.
    assign w_grant[0] = w_run & ~bus.cfg_we & w_req_valid[0] & (~w_req_valid[1] | ~r_rr_prio);
    assign w_grant[1] = w_run & ~bus.cfg_we & w_req_valid[1] & (~w_req_valid[0] |  r_rr_prio);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
            r_rr_prio  <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == LOG2_WIDTH'(WIDTH-1)) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
            end
        end else if (w_grant[0] | w_grant[1]) begin
            r_rr_prio <= w_grant[0];
        end
    end

    // Single write port shared by the init fill and config writes.
    assign w_we    = ~w_run | w_cfg_go;
    assign w_waddr = w_run ? bus.cfg_addr : r_init_cnt;
    assign w_wdata = w_run ? bus.cfg_data : (WIDTH'(r_init_cnt) + WIDTH'(1));

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_lut[w_waddr] <= w_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_rsp_valid[gi] <= 1'b0;
                    r_rsp_data[gi]  <= '0;
                end else begin
                    r_rsp_valid[gi] <= w_grant[gi];
                    if (w_grant[gi]) begin
                        r_rsp_data[gi] <= r_lut[w_req_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign bus.busy       = r_busy;
    assign bus.cfg_ready  = w_cfg_go;
    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.rsp0_valid = r_rsp_valid[0];
    assign bus.rsp0_data  = r_rsp_data[0];
    assign bus.rsp1_valid = r_rsp_valid[1];
    assign bus.rsp1_data  = r_rsp_data[1];
endmodule

// File: tb/tb_lut_access_ctrl.sv
// Scoreboard bench for lut_access_ctrl: a table-level model predicts grants and read data,
// a separate monitor pops expected responses and compares them with the DUT outputs.
module tb_lut_access_ctrl;
    localparam int LW = 3;
    localparam int W  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lut_access_ctrl_if #(.LOG2_WIDTH(LW)) bus ();

    lut_access_ctrl #(.LOG2_WIDTH(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           cyc;
        int           req;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sbq [$];
    logic [W-1:0] m_lut [W];
    int           m_init_left = W;
    int           m_last = 1;
    int           m_grant;
    logic [W-1:0] m_hold [2];
    exp_t         m_exp;
    exp_t         e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model: table contents, init length and round-robin from the rules, per cycle.
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_busy",   32'(bus.busy),       32'd1);
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            chk("rst_cfgrdy", 32'(bus.cfg_ready),  32'd0);
            chk("rst_rspv0",  32'(bus.rsp0_valid), 32'd0);
            chk("rst_rspv1",  32'(bus.rsp1_valid), 32'd0);
            chk("rst_data0",  32'(bus.rsp0_data),  32'd0);
            chk("rst_data1",  32'(bus.rsp1_data),  32'd0);
            m_init_left = W;
            m_last      = 1;
            for (int j = 0; j < W; j++) m_lut[j] = W'(j + 1);
            sbq.delete();
        end else begin
            chk("busy", 32'(bus.busy), 32'(m_init_left > 0));
            if (m_init_left > 0) begin
                chk("init_ready0", 32'(bus.req0_ready), 32'd0);
                chk("init_ready1", 32'(bus.req1_ready), 32'd0);
                chk("init_cfgrdy", 32'(bus.cfg_ready),  32'd0);
                m_init_left--;
            end else begin
                m_grant = -1;
                if (!bus.cfg_we) begin
                    if (bus.req0_valid && bus.req1_valid) m_grant = 1 - m_last;
                    else if (bus.req0_valid)              m_grant = 0;
                    else if (bus.req1_valid)              m_grant = 1;
                end
                chk("ready0", 32'(bus.req0_ready), 32'(m_grant == 0));
                chk("ready1", 32'(bus.req1_ready), 32'(m_grant == 1));
                chk("cfgrdy", 32'(bus.cfg_ready),  32'(bus.cfg_we));
                if (m_grant >= 0) begin
                    m_exp.cyc  = cyc + 1;
                    m_exp.req  = m_grant;
                    m_exp.data = (m_grant == 0) ? m_lut[bus.req0_addr] : m_lut[bus.req1_addr];
                    sbq.push_back(m_exp);
                    m_last = m_grant;
                end
                if (bus.cfg_we) m_lut[bus.cfg_addr] = bus.cfg_data;
            end
        end
    end

    // Monitor: responses must appear exactly one cycle after the grant, and data holds otherwise.
    always @(negedge clock) begin
        if (reset) begin
            m_hold[0] = '0;
            m_hold[1] = '0;
        end else begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                m_hold[e.req] = e.data;
                chk("rsp_valid0", 32'(bus.rsp0_valid), 32'(e.req == 0));
                chk("rsp_valid1", 32'(bus.rsp1_valid), 32'(e.req == 1));
                $display("rsp cyc=%0d req=%0d data=%02h exp=%02h", cyc, e.req,
                         (e.req == 0) ? bus.rsp0_data : bus.rsp1_data, e.data);
            end else begin
                chk("idle_valid0", 32'(bus.rsp0_valid), 32'd0);
                chk("idle_valid1", 32'(bus.rsp1_valid), 32'd0);
            end
            chk("rsp_data0", 32'(bus.rsp0_data), 32'(m_hold[0]));
            chk("rsp_data1", 32'(bus.rsp1_data), 32'(m_hold[1]));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0;
        bus.cfg_we     = 1'b0; bus.cfg_addr  = '0; bus.cfg_data = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    localparam logic [LW-1:0] T6_ADDR [4] = '{3'd7, 3'd0, 3'd1, 3'd7};

    initial begin
        idle_inputs();
        do_reset(3);
        repeat (W) step();

        // Sweep every address from requester 0.
        for (int a = 0; a < W; a++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = LW'(a);
            step();
        end
        idle_inputs();
        step();

        // Both requesters contend for six cycles.
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = LW'($urandom_range(0, W-1));
            bus.req1_valid = 1'b1; bus.req1_addr = LW'($urandom_range(0, W-1));
            step();
        end
        idle_inputs();
        step();

        // Config write collides with a read of the same address.
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd5; bus.cfg_data = 8'hA5;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5;
        step();
        bus.cfg_we = 1'b0;
        step();
        idle_inputs();
        step();

        // Back-to-back reads from requester 0.
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = T6_ADDR[i];
            step();
        end
        idle_inputs();
        step();

        // Requester 1 waits through the init fill.
        reset = 1'b1;
        step();
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2;
        reset = 1'b0;
        repeat (W + 1) step();
        idle_inputs();
        step();

        // Reset drops an in-flight read and restores init contents.
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd5; bus.cfg_data = 8'hFF;
        step();
        bus.cfg_we = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5;
        step();
        idle_inputs();
        do_reset(2);
        repeat (W) step();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5;
        step();
        idle_inputs();
        step();

        // Random traffic with occasional config writes and resets.
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_addr  = LW'($urandom_range(0, W-1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_addr  = LW'($urandom_range(0, W-1));
            bus.cfg_we     = ($urandom_range(0, 5) == 0);
            bus.cfg_addr   = LW'($urandom_range(0, W-1));
            bus.cfg_data   = W'($urandom_range(0, 255));
            if ($urandom_range(0, 150) == 0) begin
                do_reset(1);
            end else begin
                step();
            end
        end
        idle_inputs();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
